// File: rtl/button_input_controller_pkg.sv
// -----------------------------------------------------------------------------
// button_input_controller_pkg
// Shared project definitions for the button input controller:
//   - default debounce / timeout lengths
//   - button vector and key code widths
//   - controller FSM state encoding
//   - lowest_index(): priority encoder used to pick one of several
//     simultaneous presses (lowest bit wins)
// -----------------------------------------------------------------------------
package button_input_controller_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 1024;

    localparam int NUM_BTN = 8;
    localparam int KEY_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [KEY_W-1:0] lowest_index(input logic [NUM_BTN-1:0] vec);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = KEY_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_input_controller_if.sv
// -----------------------------------------------------------------------------
// button_input_controller_if
// Bundles the button inputs, the LED sequencer handshake and the key report
// outputs of the button input controller.
//   btn         raw push-buttons (active-high, asynchronous, bouncing)
//   led_end     completion pulse from the LED output sequencer
//   led_on      level request to the LED output sequencer
//   key_valid   one-cycle pulse on an accepted press
//   key_code    index of the accepted button, held until the next press
//   busy        high from acceptance until return to idle
//   timeout_err sticky: the last request ended by timeout
// Modports: master = the controller, slave = buttons / LED sequencer side.
// -----------------------------------------------------------------------------
interface button_input_controller_if;
    import button_input_controller_pkg::*;

    logic [NUM_BTN-1:0] btn;
    logic               led_end;
    logic               led_on;
    logic               key_valid;
    logic [KEY_W-1:0]   key_code;
    logic               busy;
    logic               timeout_err;

    modport master (
        input  btn,
        input  led_end,
        output led_on,
        output key_valid,
        output key_code,
        output busy,
        output timeout_err
    );

    modport slave (
        output btn,
        output led_end,
        input  led_on,
        input  key_valid,
        input  key_code,
        input  busy,
        input  timeout_err
    );

endinterface

// File: rtl/button_input_controller_btn_debouncer.sv
// -----------------------------------------------------------------------------
// btn_debouncer
// Synchronizes, debounces and edge-detects the raw button vector.
//   clk        system clock
//   reset      asynchronous, active-high
//   btn        raw buttons (asynchronous, bouncing)
//   debounced  debounced button vector
//   rise       one-cycle pulse per bit on a debounced 0->1 transition
// One counter is shared by all bits: any change of the synchronized vector
// restarts it, so the whole vector must be stable for DEBOUNCE_CYCLES cycles
// before the debounced vector follows.
// -----------------------------------------------------------------------------
module btn_debouncer
    import button_input_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] debounced,
    output logic [NUM_BTN-1:0] rise
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync1_reg;
    logic [NUM_BTN-1:0] sync2_reg;
    logic [NUM_BTN-1:0] cand_reg;
    logic [NUM_BTN-1:0] deb_reg;
    logic [NUM_BTN-1:0] deb_prev_reg;
    logic [CNT_W-1:0]   cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            cand_reg     <= '0;
            deb_reg      <= '0;
            deb_prev_reg <= '0;
            cnt_reg      <= '0;
        end else begin
            sync1_reg    <= btn;
            sync2_reg    <= sync1_reg;
            deb_prev_reg <= deb_reg;
            if (sync2_reg != cand_reg) begin
                // The cycle that just showed the new value is already its
                // first stable cycle, so the restarted count begins at 1.
                cand_reg <= sync2_reg;
                cnt_reg  <= CNT_W'(1);
            end else if (cnt_reg != CNT_DONE) begin
                // Saturates at CNT_DONE; never wraps.
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    deb_reg <= cand_reg;
                end
            end
        end
    end

    assign debounced = deb_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_rise
            assign rise[gi] = deb_reg[gi] & ~deb_prev_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/button_input_controller.sv
// -----------------------------------------------------------------------------
// button_input_controller
// Accepts debounced button presses and turns each one into a single request
// to the LED output sequencer.
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    button_input_controller_if.master (btn, led_end in;
//          led_on, key_valid, key_code, busy, timeout_err out)
// FSM: IDLE -> REQ on a press; REQ -> GAP on led_end or timeout;
// GAP -> IDLE after one cycle so led_on always has a low phase between
// requests. Presses seen outside IDLE are dropped.
// -----------------------------------------------------------------------------
module button_input_controller
    import button_input_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    button_input_controller_if.master bus
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_BTN-1:0] debounced;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] press_vec;

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic             key_valid_reg, key_valid_next;
    logic [KEY_W-1:0] key_code_reg, key_code_next;
    logic             timeout_err_reg, timeout_err_next;
    logic             led_on;
    logic             busy;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .reset     (reset),
        .btn       (bus.btn),
        .debounced (debounced),
        .rise      (rise)
    );

    // Only bits that are debounced high right now count as presses.
    assign press_vec = rise & debounced;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            key_valid_reg   <= 1'b0;
            key_code_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            key_valid_reg   <= key_valid_next;
            key_code_reg    <= key_code_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        timer_next       = '0;
        key_valid_next   = 1'b0;
        key_code_next    = key_code_reg;
        timeout_err_next = timeout_err_reg;
        led_on           = 1'b0;
        busy             = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|press_vec) begin
                    key_valid_next   = 1'b1;
                    key_code_next    = lowest_index(press_vec);
                    timeout_err_next = 1'b0;
                    state_next       = REQ;
                end
            end
            REQ: begin
                led_on     = 1'b1;
                busy       = 1'b1;
                timer_next = (timer_reg == TMR_FULL) ? timer_reg : timer_reg + 1'b1;
                // led_end is checked first so it wins over a coinciding timeout.
                if (bus.led_end) begin
                    state_next = GAP;
                end else if (timer_reg >= TMR_LAST) begin
                    timeout_err_next = 1'b1;
                    state_next       = GAP;
                end
            end
            GAP: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.led_on      = led_on;
    assign bus.busy        = busy;
    assign bus.key_valid   = key_valid_reg;
    assign bus.key_code    = key_code_reg;
    assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_button_input_controller.sv
// -----------------------------------------------------------------------------
// tb_button_input_controller
// Self-checking bench for button_input_controller with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=8. Expected key codes are queued when a press is driven and
// compared by a monitor whenever key_valid pulses; timing and flag behaviour
// is checked directly in the stimulus sequences.
// -----------------------------------------------------------------------------
module tb_button_input_controller;

    logic clk;
    logic reset;

    button_input_controller_if bus_if ();

    button_input_controller #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] btn;
        logic [2:0] code;
    } vec_t;

    vec_t       vecs [6];
    logic [2:0] sb [$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive a pattern from an idle, released state: key_valid must stay low
    // for 6 edges and pulse on the 7th with led_on and busy rising with it.
    task automatic press_and_check(input logic [7:0] pattern, input logic [2:0] code,
                                   input string tag);
        bus_if.btn = pattern;
        sb.push_back(code);
        ticks(6);
        check({tag, "_early_kv"}, bus_if.key_valid, 1'b0);
        check({tag, "_early_led"}, bus_if.led_on, 1'b0);
        tick();
        check({tag, "_kv"}, bus_if.key_valid, 1'b1);
        check({tag, "_code"}, bus_if.key_code, code);
        check({tag, "_led_on"}, bus_if.led_on, 1'b1);
        check({tag, "_busy"}, bus_if.busy, 1'b1);
        $display("press %s: btn=%b key_code=%0d", tag, pattern, bus_if.key_code);
    endtask

    // One-cycle led_end: led_on drops on the next edge, busy one edge later.
    task automatic finish_req(input string tag);
        bus_if.led_end = 1'b1;
        tick();
        bus_if.led_end = 1'b0;
        check({tag, "_gap_led"}, bus_if.led_on, 1'b0);
        check({tag, "_gap_busy"}, bus_if.busy, 1'b1);
        tick();
        check({tag, "_idle_busy"}, bus_if.busy, 1'b0);
    endtask

    // Scoreboard: every key_valid pulse must match the oldest queued press.
    always @(negedge clk) begin
        if (!reset && bus_if.key_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: key_valid with key_code=%0d, expected no press (t=%0t)",
                         bus_if.key_code, $time);
            end else begin
                check("sb_code", bus_if.key_code, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus_if.btn     = 8'h00;
        bus_if.led_end = 1'b0;

        vecs[0] = '{8'h01, 3'd0};
        vecs[1] = '{8'h80, 3'd7};
        vecs[2] = '{8'hA0, 3'd5};
        vecs[3] = '{8'h06, 3'd1};
        vecs[4] = '{8'hFF, 3'd0};
        vecs[5] = '{8'h40, 3'd6};

        // Reset state
        ticks(3);
        check("rst_led_on", bus_if.led_on, 1'b0);
        check("rst_key_valid", bus_if.key_valid, 1'b0);
        check("rst_key_code", bus_if.key_code, 3'd0);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_timeout_err", bus_if.timeout_err, 1'b0);
        reset = 1'b0;
        ticks(12);

        // Clean press of btn[3], then a single led_end
        press_and_check(8'h08, 3'd3, "clean");
        tick();
        check("clean_single_pulse", bus_if.key_valid, 1'b0);
        check("clean_hold_led", bus_if.led_on, 1'b1);
        finish_req("clean");
        ticks(4);
        bus_if.btn = 8'h00;
        ticks(10);
        check("release_no_busy", bus_if.busy, 1'b0);

        // led_end while idle is ignored
        bus_if.led_end = 1'b1;
        tick();
        bus_if.led_end = 1'b0;
        check("idle_led_end_led", bus_if.led_on, 1'b0);
        check("idle_led_end_busy", bus_if.busy, 1'b0);

        // Table of press patterns, each held well past return to idle
        for (int i = 0; i < 6; i++) begin
            press_and_check(vecs[i].btn, vecs[i].code, $sformatf("vec%0d", i));
            finish_req($sformatf("vec%0d", i));
            ticks(10);
            bus_if.btn = 8'h00;
            ticks(10);
        end

        // Bounce on btn[0]: 10 toggles 2 cycles apart, then held high
        for (int i = 0; i < 10; i++) begin
            bus_if.btn[0] = ~bus_if.btn[0];
            ticks(2);
        end
        check("bounce_idle", bus_if.busy, 1'b0);
        press_and_check(8'h01, 3'd0, "bounce");
        finish_req("bounce");
        bus_if.btn = 8'h00;
        ticks(10);

        // Timeout: no led_end after a btn[1] press
        press_and_check(8'h02, 3'd1, "to");
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_led_hold", bus_if.led_on, 1'b1);
        end
        tick();
        check("to_led_fall", bus_if.led_on, 1'b0);
        check("to_err_set", bus_if.timeout_err, 1'b1);
        check("to_gap_busy", bus_if.busy, 1'b1);
        tick();
        check("to_idle_busy", bus_if.busy, 1'b0);
        bus_if.btn = 8'h00;
        ticks(10);
        check("to_err_sticky", bus_if.timeout_err, 1'b1);
        press_and_check(8'h10, 3'd4, "to_clear");
        check("to_err_cleared", bus_if.timeout_err, 1'b0);
        finish_req("to_clear");
        bus_if.btn = 8'h00;
        ticks(10);

        // led_end on the timeout terminal cycle: led_end wins
        press_and_check(8'h80, 3'd7, "coin");
        ticks(7);
        bus_if.led_end = 1'b1;
        tick();
        bus_if.led_end = 1'b0;
        check("coin_led_off", bus_if.led_on, 1'b0);
        check("coin_no_err", bus_if.timeout_err, 1'b0);
        tick();
        check("coin_idle", bus_if.busy, 1'b0);
        bus_if.btn = 8'h00;
        ticks(10);

        // Press during REQ is dropped; reset mid-request; held button re-presses
        press_and_check(8'h04, 3'd2, "drop");
        bus_if.btn = 8'h44;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("drop_no_kv", bus_if.key_valid, 1'b0);
        end
        check("drop_in_req", bus_if.led_on, 1'b1);
        reset = 1'b1;
        #1;
        check("arst_led_on", bus_if.led_on, 1'b0);
        check("arst_busy", bus_if.busy, 1'b0);
        check("arst_key_valid", bus_if.key_valid, 1'b0);
        check("arst_key_code", bus_if.key_code, 3'd0);
        check("arst_timeout_err", bus_if.timeout_err, 1'b0);
        ticks(2);
        reset = 1'b0;
        sb.push_back(3'd2);
        ticks(6);
        check("rep_early_kv", bus_if.key_valid, 1'b0);
        tick();
        check("rep_kv", bus_if.key_valid, 1'b1);
        check("rep_code", bus_if.key_code, 3'd2);
        check("rep_led_on", bus_if.led_on, 1'b1);
        $display("press after reset: btn=%b key_code=%0d", bus_if.btn, bus_if.key_code);
        finish_req("rep");
        bus_if.btn = 8'h00;
        ticks(10);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
